gpu_instruction_encoder: RTL
============================

GPU_INSTRUCTION_ENCODER -- requirements
Module: gpu_instruction_encoder

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset: `clk` (input, 1, rising-edge clock) and `n_rst` (input, 1, synchronous active-low reset).
REQ-002 req_valid_i  input  1  draw request present.
REQ-003 req_ready_o  output  1  encoder can accept a request.
REQ-004 req_shape_i  input  2  request type: 00 line, 01 rect, 10 circle, 11 reset.
REQ-005 x1_i/x2_i  input  WIDTH_BITS  x coordinates; y1_i/y2_i  input  HEIGHT_BITS  y coordinates.
REQ-006 rad_i  input  WIDTH_BITS  radius; r_i/g_i/b_i  input  CHANNEL_BITS  color channels.
REQ-007 stall_i  input  1  downstream cannot take a word this cycle.
REQ-008 opcode_o  output  4  command opcode; parameters_o  output  25  command parameters; command_o  output  1  word valid.
REQ-009 busy_o  output  1  high whenever the FSM is not IDLE.

Function
REQ-010 A request SHALL be accepted on a rising edge where req_valid_i=1 and req_ready_o=1, and all request fields SHALL be captured on that edge.
REQ-011 req_ready_o SHALL be registered and high only while the FSM is IDLE.
REQ-012 Word sequences SHALL be: line -> set_xy1(1), set_xy2(2), draw_line(4); rect -> 1, 2, draw_rect(5); circle -> 1, set_radius(3), draw_circle(6); reset -> opcode 0 with parameters 0.
REQ-013 FSM states SHALL be IDLE, XY1, XY2, RAD and DRAW; accept goes to the first non-skipped state, each consumed word advances to the next state, and a consumed DRAW word returns to IDLE.
REQ-014 Outputs SHALL be registered; the first word SHALL appear (command_o=1) in the cycle after accept.
REQ-015 A word SHALL be consumed on an edge where command_o=1 and stall_i=0; while stall_i=1, opcode_o, parameters_o and command_o SHALL hold unchanged.
REQ-016 Unstalled throughput SHALL be one word per cycle, and req_ready_o SHALL rise on the edge that consumes the DRAW word.
REQ-017 Packing SHALL be: xy -> x in [WIDTH_BITS-1:0] and y in [WIDTH_BITS+HEIGHT_BITS-1:WIDTH_BITS]; radius in [WIDTH_BITS-1:0]; color -> b [C-1:0], g [2C-1:C], r [3C-1:2C] with C=CHANNEL_BITS; all unused parameter bits SHALL be 0.
REQ-018 Shadow registers (xy1, xy2, rad, each with a valid bit) SHALL update only when the corresponding set_* word is consumed.
REQ-019 A set_* state SHALL be skipped when its shadow is valid and equal to the captured value; the draw word SHALL never be skipped.
REQ-020 A consumed reset word SHALL clear all shadow valid bits.
REQ-021 When command_o=0, opcode_o and parameters_o SHALL be 0.

Reset
REQ-022 While n_rst=0 at a clock edge: the FSM SHALL go to IDLE; command_o, opcode_o, parameters_o, busy_o and req_ready_o SHALL be 0; all shadow valid bits SHALL be cleared.
REQ-023 req_ready_o SHALL be 1 from the first edge with n_rst=1.
REQ-024 Reset asserted mid-sequence SHALL drop the remaining words with no partial replay.

Structure
REQ-025 WIDTH_BITS=10, HEIGHT_BITS=9, CHANNEL_BITS=8, the opcode constants and the shape codes SHALL live in the shared gpu_definitions.vh.
REQ-026 Word formatting SHALL be a combinational sub-module gpu_param_packer (state and captured request in, opcode and parameters out).

Verification
REQ-027 Line (10,20)->(100,200), color r=FF g=80 b=01, no stall -> three consecutive words 1/0x0500A, 2/0x32064, 4/0xFF8001 starting the cycle after accept; ready high after the third word.
REQ-028 Repeat as rect with the same coordinates -> single word 5/0xFF8001.
REQ-029 Circle center (320,240), rad 50, color 0x000000 -> 1/0x3C140, 3/0x00032, 6/0x000000.
REQ-030 stall_i=1 for 4 cycles while the set_xy2 word is presented -> outputs held and stable; exactly 3 words consumed in total, no duplicates.
REQ-031 Reset request, then the REQ-027 line again -> 0/0x0, followed by all three line words (no skips).
REQ-032 n_rst=0 for 1 cycle while the XY2 word is presented -> command_o=0 next cycle, ready high afterwards, next identical line emits all 3 words.

Source files
------------

// File: rtl/gpu_instruction_encoder_pkg.sv
// ============================================================================
// Module      : gpu_instruction_encoder_pkg
// Description : Shared GPU definitions: geometry widths, opcodes, shape codes,
//               encoder state type and word-sequencing helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpu_instruction_encoder_pkg;

    localparam int WIDTH_BITS   = 10;
    localparam int HEIGHT_BITS  = 9;
    localparam int CHANNEL_BITS = 8;
    localparam int OPCODE_BITS  = 4;
    localparam int PARAM_BITS   = 25;
    localparam int XY_BITS      = WIDTH_BITS + HEIGHT_BITS;
    localparam int COLOR_BITS   = 3 * CHANNEL_BITS;

    localparam logic [OPCODE_BITS-1:0] OP_RESET       = 4'd0;
    localparam logic [OPCODE_BITS-1:0] OP_SET_XY1     = 4'd1;
    localparam logic [OPCODE_BITS-1:0] OP_SET_XY2     = 4'd2;
    localparam logic [OPCODE_BITS-1:0] OP_SET_RADIUS  = 4'd3;
    localparam logic [OPCODE_BITS-1:0] OP_DRAW_LINE   = 4'd4;
    localparam logic [OPCODE_BITS-1:0] OP_DRAW_RECT   = 4'd5;
    localparam logic [OPCODE_BITS-1:0] OP_DRAW_CIRCLE = 4'd6;

    typedef enum logic [1:0] {
        SHAPE_LINE   = 2'b00,
        SHAPE_RECT   = 2'b01,
        SHAPE_CIRCLE = 2'b10,
        SHAPE_RESET  = 2'b11
    } shape_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_XY1  = 3'd1,
        ST_XY2  = 3'd2,
        ST_RAD  = 3'd3,
        ST_DRAW = 3'd4
    } state_t;

    typedef struct packed {
        shape_t                  shape;
        logic [WIDTH_BITS-1:0]   x1;
        logic [HEIGHT_BITS-1:0]  y1;
        logic [WIDTH_BITS-1:0]   x2;
        logic [HEIGHT_BITS-1:0]  y2;
        logic [WIDTH_BITS-1:0]   rad;
        logic [CHANNEL_BITS-1:0] r;
        logic [CHANNEL_BITS-1:0] g;
        logic [CHANNEL_BITS-1:0] b;
    } req_t;

    // State that follows 'cur' once its word is consumed (or once accepted
    // from IDLE), skipping set_* states whose shadows already match.
    function automatic state_t next_in_sequence(
        input state_t cur,
        input shape_t shape,
        input logic   need_xy1,
        input logic   need_xy2,
        input logic   need_rad
    );
        if (cur == ST_DRAW) begin
            return ST_IDLE;
        end
        if (shape == SHAPE_RESET) begin
            return ST_DRAW;
        end
        if (cur == ST_IDLE && need_xy1) begin
            return ST_XY1;
        end
        if (cur == ST_IDLE || cur == ST_XY1) begin
            if (shape == SHAPE_CIRCLE && need_rad) begin
                return ST_RAD;
            end
            if (shape != SHAPE_CIRCLE && need_xy2) begin
                return ST_XY2;
            end
        end
        return ST_DRAW;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpu_param_packer.sv
// ============================================================================
// Module      : gpu_param_packer
// Description : Combinational formatter mapping encoder state plus captured
//               request onto an opcode and zero-padded parameter word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpu_param_packer
    import gpu_instruction_encoder_pkg::*;
(
    input  state_t                 state,
    input  req_t                   req,
    output logic [OPCODE_BITS-1:0] opcode,
    output logic [PARAM_BITS-1:0]  parameters
);

    always_comb begin
        opcode     = OP_RESET;
        parameters = '0;
        case (state)
            ST_XY1: begin
                opcode     = OP_SET_XY1;
                parameters = PARAM_BITS'({req.y1, req.x1});
            end
            ST_XY2: begin
                opcode     = OP_SET_XY2;
                parameters = PARAM_BITS'({req.y2, req.x2});
            end
            ST_RAD: begin
                opcode     = OP_SET_RADIUS;
                parameters = PARAM_BITS'(req.rad);
            end
            ST_DRAW: begin
                case (req.shape)
                    SHAPE_LINE:   opcode = OP_DRAW_LINE;
                    SHAPE_RECT:   opcode = OP_DRAW_RECT;
                    SHAPE_CIRCLE: opcode = OP_DRAW_CIRCLE;
                    default:      opcode = OP_RESET;
                endcase
                // The reset command carries no payload.
                if (req.shape != SHAPE_RESET) begin
                    parameters = PARAM_BITS'({req.r, req.g, req.b});
                end
            end
            default: begin
                opcode     = OP_RESET;
                parameters = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/gpu_instruction_encoder.sv
// ============================================================================
// Module      : gpu_instruction_encoder
// Description : Turns draw requests into a stream of GPU command words,
//               suppressing set_* words whose shadowed value is unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpu_instruction_encoder
    import gpu_instruction_encoder_pkg::*;
(
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [1:0]              req_shape_i,
    input  logic [WIDTH_BITS-1:0]   x1_i,
    input  logic [HEIGHT_BITS-1:0]  y1_i,
    input  logic [WIDTH_BITS-1:0]   x2_i,
    input  logic [HEIGHT_BITS-1:0]  y2_i,
    input  logic [WIDTH_BITS-1:0]   rad_i,
    input  logic [CHANNEL_BITS-1:0] r_i,
    input  logic [CHANNEL_BITS-1:0] g_i,
    input  logic [CHANNEL_BITS-1:0] b_i,
    input  logic                    stall_i,
    output logic [OPCODE_BITS-1:0]  opcode_o,
    output logic [PARAM_BITS-1:0]   parameters_o,
    output logic                    command_o,
    output logic                    busy_o
);

    state_t                 r_state;
    req_t                   r_req;
    logic                   r_need_xy1;
    logic                   r_need_xy2;
    logic                   r_need_rad;
    logic                   r_ready;
    logic                   r_command;
    logic [OPCODE_BITS-1:0] r_opcode;
    logic [PARAM_BITS-1:0]  r_params;

    logic [XY_BITS-1:0]     r_xy1;
    logic [XY_BITS-1:0]     r_xy2;
    logic [WIDTH_BITS-1:0]  r_rad;
    logic                   r_xy1_valid;
    logic                   r_xy2_valid;
    logic                   r_rad_valid;

    state_t                 w_state_nxt;
    req_t                   w_req_in;
    req_t                   w_req_nxt;
    logic                   w_need_xy1_nxt;
    logic                   w_need_xy2_nxt;
    logic                   w_need_rad_nxt;
    logic                   w_accept;
    logic                   w_consume;
    logic [OPCODE_BITS-1:0] w_opcode_nxt;
    logic [PARAM_BITS-1:0]  w_params_nxt;

    assign w_accept  = req_valid_i && r_ready;
    assign w_consume = r_command && !stall_i;

    always_comb begin
        w_req_in       = '0;
        w_req_in.shape = shape_t'(req_shape_i);
        w_req_in.x1    = x1_i;
        w_req_in.y1    = y1_i;
        w_req_in.x2    = x2_i;
        w_req_in.y2    = y2_i;
        w_req_in.rad   = rad_i;
        w_req_in.r     = r_i;
        w_req_in.g     = g_i;
        w_req_in.b     = b_i;
    end

    // Skip decisions are taken once at accept: the shadows only change by
    // consuming this same sequence's words, so the answer cannot go stale.
    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_req;
        w_need_xy1_nxt = r_need_xy1;
        w_need_xy2_nxt = r_need_xy2;
        w_need_rad_nxt = r_need_rad;
        if (w_accept) begin
            w_req_nxt      = w_req_in;
            w_need_xy1_nxt = !(r_xy1_valid && r_xy1 == {y1_i, x1_i});
            w_need_xy2_nxt = !(r_xy2_valid && r_xy2 == {y2_i, x2_i});
            w_need_rad_nxt = !(r_rad_valid && r_rad == rad_i);
            w_state_nxt    = next_in_sequence(ST_IDLE, w_req_in.shape,
                                              w_need_xy1_nxt, w_need_xy2_nxt,
                                              w_need_rad_nxt);
        end else if (w_consume) begin
            w_state_nxt = next_in_sequence(r_state, r_req.shape,
                                           r_need_xy1, r_need_xy2, r_need_rad);
        end
    end

    gpu_param_packer u_packer (
        .state      (w_state_nxt),
        .req        (w_req_nxt),
        .opcode     (w_opcode_nxt),
        .parameters (w_params_nxt)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state     <= ST_IDLE;
            r_req       <= '0;
            r_need_xy1  <= 1'b0;
            r_need_xy2  <= 1'b0;
            r_need_rad  <= 1'b0;
            r_ready     <= 1'b0;
            r_command   <= 1'b0;
            r_opcode    <= '0;
            r_params    <= '0;
            r_xy1_valid <= 1'b0;
            r_xy2_valid <= 1'b0;
            r_rad_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_req_nxt;
            r_need_xy1 <= w_need_xy1_nxt;
            r_need_xy2 <= w_need_xy2_nxt;
            r_need_rad <= w_need_rad_nxt;
            r_ready    <= (w_state_nxt == ST_IDLE);
            r_command  <= (w_state_nxt != ST_IDLE);
            r_opcode   <= w_opcode_nxt;
            r_params   <= w_params_nxt;
            if (w_consume) begin
                case (r_state)
                    ST_XY1: r_xy1_valid <= 1'b1;
                    ST_XY2: r_xy2_valid <= 1'b1;
                    ST_RAD: r_rad_valid <= 1'b1;
                    ST_DRAW: begin
                        if (r_req.shape == SHAPE_RESET) begin
                            r_xy1_valid <= 1'b0;
                            r_xy2_valid <= 1'b0;
                            r_rad_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Shadow payloads carry no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (w_consume) begin
            if (r_state == ST_XY1) r_xy1 <= {r_req.y1, r_req.x1};
            if (r_state == ST_XY2) r_xy2 <= {r_req.y2, r_req.x2};
            if (r_state == ST_RAD) r_rad <= r_req.rad;
        end
    end

    assign req_ready_o  = r_ready;
    assign command_o    = r_command;
    assign opcode_o     = r_opcode;
    assign parameters_o = r_params;
    assign busy_o       = (r_state != ST_IDLE);

endmodule

`default_nettype wire
